rtc_write_cycle: RTL
====================

# rtc_write_cycle

Write-cycle generator for the multiplexed address/data RTC bus. It is the write-side counterpart of the read-side tACC delay block. On a one-cycle start request it runs a complete two-phase write: an address strobe, then a data strobe, each with programmable setup, WR-pulse and hold times. It reports completion with a one-cycle done pulse. It sits between the RTC control FSM and the bus pins, and owns CS/WR/A-D/AD-drive for the whole write.

## Interface

Parameters:
- T_SETUP, 2: cycles from CS/AD valid to WR falling, per phase
- T_PULSE, 7: cycles WR held low, per phase
- T_HOLD, 2: cycles AD/CS held after WR rising, per phase
- T_GAP, 4: cycles CS high between address and data phases
- Legal range for every parameter is 1..255. The counter is 8 bits. Values outside the range are unsupported.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  write request; sampled only in IDLE
- addr_i  in  8  register address; captured on the accepting edge
- data_i  in  8  write data; captured on the accepting edge
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse in DONE
- cs_n_o  out  1  chip select, active low
- wr_n_o  out  1  write strobe, active low
- rd_n_o  out  1  read strobe; tied to 1 (this block never reads)
- ad_sel_o  out  1  A/D line: 0 = address phase, 1 = data phase
- ad_oe_o  out  1  AD bus output enable for the top-level tristate
- ad_o  out  8  value driven on the AD bus

## Operation

- States: IDLE, A_SETUP, A_WR, A_HOLD, GAP, D_SETUP, D_WR, D_HOLD, DONE.
- Outputs are registered and depend only on the current state. No glitches on cs_n_o or wr_n_o.
- IDLE: cs_n=1, wr_n=1, ad_sel=0, ad_oe=0, ad_o=0x00, busy=0, done=0. If start_i=1, latch addr_i and data_i and go to A_SETUP.
- A_SETUP for T_SETUP cycles: cs_n=0, wr_n=1, ad_sel=0, ad_oe=1, ad_o=addr.
- A_WR for T_PULSE cycles: same as A_SETUP but wr_n=0.
- A_HOLD for T_HOLD cycles: same as A_SETUP (wr_n=1).
- GAP for T_GAP cycles: cs_n=1, wr_n=1, ad_oe=0, ad_sel=0, ad_o=0x00.
- D_SETUP, D_WR, D_HOLD: same as the address phase but with ad_sel=1 and ad_o=data.
- DONE for 1 cycle: bus outputs as in IDLE, busy=1, done=1. Then go to IDLE.
- A single 8-bit down-counter is loaded with (N-1) on entry to each timed state. The state advances when the counter reads 0. No wrap-around is possible inside the legal range.
- Latched addr/data are held for the whole transaction. Changes on addr_i/data_i after acceptance have no effect.
- rd_n_o is 1 at all times, including during reset.

## Timing

- Reset: on any edge with rst_i=1, the next cycle is IDLE with all outputs at their IDLE values (busy=0, done=0, cs_n=1, wr_n=1, ad_oe=0). The counter and latches are cleared to 0.
- Reset mid-transaction aborts at once. No done pulse is produced, and CS/WR release on the following cycle.
- If start_i is accepted at edge k, the bus enters A_SETUP at cycle k+1.
- wr_n_o falls at cycle k+1+T_SETUP.
- The total busy length is 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles. With the defaults that is 27 cycles: done_o is high in cycle k+27, and busy_o is high for cycles k+1..k+27.
- wr_n_o is low for exactly T_PULSE consecutive cycles per phase, 2 pulses per transaction.
- start_i while busy: ignored, not queued.
- start_i held continuously: DONE is followed by one IDLE cycle, which accepts the request. The next A_SETUP begins 2 cycles after done_o.
- start_i and rst_i high together: reset wins.

## Test plan

- Reset with start_i=1 -> all outputs at IDLE values, rd_n_o=1, and no transaction begins while rst_i=1.
- Defaults, start pulse with addr=0x21, data=0x45 -> cs_n low for cycles 2..12 with ad_o=0x21, ad_sel=0; wr_n low for cycles 4..10; gap on cycles 13..16; data phase on cycles 17..27 with ad_o=0x45, ad_sel=1, wr_n low for 19..25; done_o high in cycle 28 only. Cycles are counted from the start edge as cycle 1.
- Start pulse, then start_i=1 plus new addr/data during busy -> first transaction is unaffected; exactly one done_o; no second transaction.
- start_i held high for 60 cycles -> two complete transactions, the second A_SETUP 2 cycles after the first done_o.
- rst_i asserted for 1 cycle during D_WR -> next cycle wr_n=1, cs_n=1, busy=0, and done_o never pulses.
- Override T_SETUP=T_PULSE=T_HOLD=T_GAP=1 -> wr_n low for exactly 1 cycle per phase, and done_o 8 cycles after acceptance.

Source files
------------

// File: rtl/rtc_write_cycle_if.sv
// -----------------------------------------------------------------------------
// rtc_write_cycle_if
// Groups the request handshake and the RTC bus pins of the write-cycle
// generator.
//   start_i  : one-cycle write request from the RTC control FSM
//   addr_i   : register address, captured when the request is accepted
//   data_i   : write data, captured when the request is accepted
//   busy_o   : high while a write is in progress (including DONE)
//   done_o   : one-cycle completion pulse
//   cs_n_o   : chip select, active low
//   wr_n_o   : write strobe, active low
//   rd_n_o   : read strobe, constantly high
//   ad_sel_o : A/D line, 0 = address phase, 1 = data phase
//   ad_oe_o  : output enable for the top-level AD tristate
//   ad_o     : value driven onto the AD bus
// The master modport is the requester/pin side. The slave modport is the
// write-cycle generator.
// -----------------------------------------------------------------------------
interface rtc_write_cycle_if;
  logic       start_i;
  logic [7:0] addr_i;
  logic [7:0] data_i;
  logic       busy_o;
  logic       done_o;
  logic       cs_n_o;
  logic       wr_n_o;
  logic       rd_n_o;
  logic       ad_sel_o;
  logic       ad_oe_o;
  logic [7:0] ad_o;

  modport master (
    output start_i, addr_i, data_i,
    input  busy_o, done_o, cs_n_o, wr_n_o, rd_n_o, ad_sel_o, ad_oe_o, ad_o
  );

  modport slave (
    input  start_i, addr_i, data_i,
    output busy_o, done_o, cs_n_o, wr_n_o, rd_n_o, ad_sel_o, ad_oe_o, ad_o
  );
endinterface

// File: rtl/rtc_write_cycle.sv
// -----------------------------------------------------------------------------
// rtc_write_cycle
// Two-phase write-cycle generator for the multiplexed address/data RTC bus.
// A one-cycle start request runs an address strobe and then a data strobe.
// Each strobe has programmable setup, WR-pulse and hold times, and the two
// phases are separated by a CS-high gap. Completion is reported with a
// one-cycle done pulse.
// Ports:
//   clk_i : system clock, rising edge
//   rst_i : synchronous, active-high reset
//   bus   : request handshake and RTC bus pins (slave modport)
// Parameters (legal range 1..255 each):
//   T_SETUP : CS/AD valid to WR falling, per phase
//   T_PULSE : WR low time, per phase
//   T_HOLD  : AD/CS hold after WR rising, per phase
//   T_GAP   : CS high time between the phases
// -----------------------------------------------------------------------------
module rtc_write_cycle #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 7,
  parameter int T_HOLD  = 2,
  parameter int T_GAP   = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  rtc_write_cycle_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    A_SETUP = 4'd1,
    A_WR    = 4'd2,
    A_HOLD  = 4'd3,
    GAP     = 4'd4,
    D_SETUP = 4'd5,
    D_WR    = 4'd6,
    D_HOLD  = 4'd7,
    DONE    = 4'd8
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       wr_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad;
  } bus_out_t;

  // The counter is loaded with N-1 so a state lasts N cycles and exits on 0.
  localparam logic [7:0] SETUP_LD = 8'(T_SETUP - 1);
  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] HOLD_LD  = 8'(T_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

  localparam bus_out_t IDLE_OUT = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] cnt_r;
  logic [7:0] cnt_nxt_s;
  logic [7:0] addr_r;
  logic [7:0] addr_nxt_s;
  logic [7:0] data_r;
  logic [7:0] data_nxt_s;
  bus_out_t   out_r;

  // Output values for a given state. Applied to the next state so the
  // registered pins line up with the state they belong to.
  function automatic bus_out_t decode_out(state_t st, logic [7:0] addr, logic [7:0] data);
    bus_out_t o;
    o = IDLE_OUT;
    case (st)
      A_SETUP, A_HOLD: o = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, addr};
      A_WR:            o = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, addr};
      GAP:             o = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      D_SETUP, D_HOLD: o = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, data};
      D_WR:            o = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, data};
      DONE:            o = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      default:         o = IDLE_OUT;
    endcase
    return o;
  endfunction

  // Next-state, counter and request-latch logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    addr_nxt_s  = addr_r;
    data_nxt_s  = data_r;
    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt_s = A_SETUP;
          cnt_nxt_s   = SETUP_LD;
          addr_nxt_s  = bus.addr_i;
          data_nxt_s  = bus.data_i;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      A_SETUP, D_SETUP: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = (state_r == A_SETUP) ? A_WR : D_WR;
          cnt_nxt_s   = PULSE_LD;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      A_WR, D_WR: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = (state_r == A_WR) ? A_HOLD : D_HOLD;
          cnt_nxt_s   = HOLD_LD;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      A_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = GAP_LD;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      GAP: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = D_SETUP;
          cnt_nxt_s   = SETUP_LD;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      D_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_nxt_s = DONE;
          cnt_nxt_s   = 8'd0;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, counter, latches and registered pin values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      addr_r  <= 8'h00;
      data_r  <= 8'h00;
      out_r   <= IDLE_OUT;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      addr_r  <= addr_nxt_s;
      data_r  <= data_nxt_s;
      out_r   <= decode_out(state_nxt_s, addr_nxt_s, data_nxt_s);
    end
  end

  assign bus.busy_o   = out_r.busy;
  assign bus.done_o   = out_r.done;
  assign bus.cs_n_o   = out_r.cs_n;
  assign bus.wr_n_o   = out_r.wr_n;
  assign bus.ad_sel_o = out_r.ad_sel;
  assign bus.ad_oe_o  = out_r.ad_oe;
  assign bus.ad_o     = out_r.ad;
  // This block never reads, so the read strobe is permanently inactive.
  assign bus.rd_n_o   = 1'b1;

endmodule
